stopwatch_ctrl: RTL and testbench

- Sequencing controller for the stopwatch's 4-digit MM:SS seven-segment display path.
- Owns the BCD time registers (MT, MO, ST, SO) and the global display enable (EN) that feed the display-multiplex block.
- Runs a RUNNING/PAUSED/ADJUST state machine driven by debounced button pulses and by tick enables from the clock divider.
- Sits between the clock divider and debouncers on one side and the display mux on the other.

---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/bcd_mod60.sv | 58 +++++
 rtl/stopwatch_ctrl.sv | 115 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch sequencing controller:
// state encoding and BCD digit limits.
package stopwatch_pkg;

    localparam logic [1:0] ST_PAUSED  = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_ADJUST  = 2'd2;

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..(MAX_TENS)9 with synchronous clear
// and a carry that fires on the wrap back to 00.
module bcd_mod60
    import stopwatch_pkg::*;
#(
    parameter int MAX_TENS = int'(BCD_MAX_TENS)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry_out
);

    localparam logic [3:0] TENS_TOP = 4'(MAX_TENS);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       ones_top;
    logic       tens_top;

    // Next digit values; clear wins over increment.
    always_comb begin
        ones_top  = (ones_q >= BCD_MAX_ONES);
        tens_top  = (tens_q >= TENS_TOP);
        carry_out = inc & ~clr & ones_top & tens_top;
        tens_d    = tens_q;
        ones_d    = ones_q;
        if (clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc) begin
            if (ones_top) begin
                ones_d = 4'd0;
                tens_d = tens_top ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: RUNNING/PAUSED/ADJUST FSM,
// MM:SS BCD time registers and blinking display enable.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter bit START_RUNNING = 1'b0,
    parameter int MAX_TENS      = int'(BCD_MAX_TENS)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK_1HZ,
    input  logic       TICK_2HZ,
    input  logic       TICK_BLINK,
    input  logic       BTN_PAUSE,
    input  logic       BTN_CLR,
    input  logic       ADJ,
    input  logic       SEL,
    output logic [3:0] MT,
    output logic [3:0] MO,
    output logic [3:0] ST,
    output logic [3:0] SO,
    output logic       EN,
    output logic       PAUSED
);

    localparam logic [1:0] RST_STATE =
        START_RUNNING ? ST_RUNNING : ST_PAUSED;

    logic [1:0] state_q, state_d;
    logic       blink_q, blink_d;
    logic       en_q, en_d;
    logic       paused_q, paused_d;

    logic run_now;
    logic adj_now;
    logic sec_inc;
    logic min_inc;
    logic sec_carry;
    logic min_carry;

    // Increment enables are decoded from the pre-edge state.
    always_comb begin
        run_now = (state_q == ST_RUNNING);
        adj_now = (state_q == ST_ADJUST);
        sec_inc = (run_now & TICK_1HZ)
                | (adj_now & TICK_2HZ & SEL);
        min_inc = (run_now & sec_carry)
                | (adj_now & TICK_2HZ & ~SEL);
    end

    // Next state, blink phase and registered status outputs.
    always_comb begin
        state_d = state_q;
        if (ADJ) begin
            state_d = ST_ADJUST;
        end else if (state_q == ST_ADJUST) begin
            state_d = ST_PAUSED;
        end else if (BTN_PAUSE) begin
            state_d = (state_q == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
        end

        // Phase restarts at 1 on every entry to ADJUST.
        if (state_q != ST_ADJUST) begin
            blink_d = 1'b1;
        end else begin
            blink_d = TICK_BLINK ? ~blink_q : blink_q;
        end

        en_d     = (state_d == ST_ADJUST) ? blink_d : 1'b1;
        paused_d = (state_d != ST_RUNNING);
    end

    // Control registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= RST_STATE;
            blink_q  <= 1'b1;
            en_q     <= 1'b1;
            paused_q <= (RST_STATE != ST_RUNNING);
        end else begin
            state_q  <= state_d;
            blink_q  <= blink_d;
            en_q     <= en_d;
            paused_q <= paused_d;
        end
    end

    bcd_mod60 #(
        .MAX_TENS (MAX_TENS)
    ) u_sec (
        .clk       (CLK),
        .rst       (RST),
        .inc       (sec_inc),
        .clr       (BTN_CLR),
        .tens      (ST),
        .ones      (SO),
        .carry_out (sec_carry)
    );

    bcd_mod60 #(
        .MAX_TENS (MAX_TENS)
    ) u_min (
        .clk       (CLK),
        .rst       (RST),
        .inc       (min_inc),
        .clr       (BTN_CLR),
        .tens      (MT),
        .ones      (MO),
        .carry_out (min_carry)
    );

    assign EN     = en_q;
    assign PAUSED = paused_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues expected
// display state, a negedge monitor pops and compares.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick1 = 1'b0;
    logic       tick2 = 1'b0;
    logic       tickb = 1'b0;
    logic       bpause = 1'b0;
    logic       bclr = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] mt, mo, st, so;
    logic       en, paused;

    typedef struct {
        string      name;
        logic [3:0] mt, mo, st, so;
        logic       en, paused;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    stopwatch_ctrl dut (
        .CLK        (clk),
        .RST        (rst),
        .TICK_1HZ   (tick1),
        .TICK_2HZ   (tick2),
        .TICK_BLINK (tickb),
        .BTN_PAUSE  (bpause),
        .BTN_CLR    (bclr),
        .ADJ        (adj),
        .SEL        (sel),
        .MT         (mt),
        .MO         (mo),
        .ST         (st),
        .SO         (so),
        .EN         (en),
        .PAUSED     (paused)
    );

    always #5 clk = ~clk;

    function automatic void cmp(input exp_t e);
        n_tests++;
        if (mt !== e.mt || mo !== e.mo || st !== e.st || so !== e.so
            || en !== e.en || paused !== e.paused) begin
            n_fail++;
            $display("FAIL %s: got %0d%0d:%0d%0d en=%b p=%b want %0d%0d:%0d%0d en=%b p=%b",
                     e.name, mt, mo, st, so, en, paused,
                     e.mt, e.mo, e.st, e.so, e.en, e.paused);
        end
        n_tests++;
        if (mt > 4'd5 || mo > 4'd9 || st > 4'd5 || so > 4'd9) begin
            n_fail++;
            $display("FAIL %s_range: got %0d%0d:%0d%0d want BCD digits",
                     e.name, mt, mo, st, so);
        end
    endfunction

    // Monitor: one expected entry per sampled cycle.
    always @(negedge clk) begin
        if (q.size() != 0) cmp(q.pop_front());
    end

    task automatic expect_st(input string name,
                             input int m, input int s,
                             input logic e, input logic p);
        exp_t x;
        x.name   = name;
        x.mt     = 4'(m / 10);
        x.mo     = 4'(m % 10);
        x.st     = 4'(s / 10);
        x.so     = 4'(s % 10);
        x.en     = e;
        x.paused = p;
        q.push_back(x);
    endtask

    // One clock with the given pulses; returns at posedge+1.
    task automatic cyc(input logic t1, input logic t2, input logic tb,
                       input logic bp, input logic bc);
        tick1  = t1;
        tick2  = t2;
        tickb  = tb;
        bpause = bp;
        bclr   = bc;
        @(posedge clk);
        #1;
        tick1  = 1'b0;
        tick2  = 1'b0;
        tickb  = 1'b0;
        bpause = 1'b0;
        bclr   = 1'b0;
    endtask

    task automatic steps2(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t r;
        repeat (2) @(posedge clk);
        #1;
        expect_st("reset", 0, 0, 1'b1, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            expect_st("paused_tick", 0, 0, 1'b1, 1'b1);
        end

        // Preload 09:59 and run one second.
        adj = 1'b1;
        sel = 1'b1;
        idle();
        expect_st("adj_enter", 0, 0, 1'b1, 1'b1);
        steps2(59);
        expect_st("adj_sec59", 0, 59, 1'b1, 1'b1);
        sel = 1'b0;
        steps2(9);
        expect_st("adj_min09", 9, 59, 1'b1, 1'b1);
        adj = 1'b0;
        idle();
        expect_st("adj_exit", 9, 59, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_st("resume", 9, 59, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_st("carry_1000", 10, 0, 1'b1, 1'b0);

        // Preload 59:59, check minute-only wrap, then full wrap.
        adj = 1'b1;
        sel = 1'b1;
        idle();
        steps2(59);
        sel = 1'b0;
        steps2(49);
        expect_st("pre_5959", 59, 59, 1'b1, 1'b1);
        steps2(1);
        expect_st("min_wrap", 0, 59, 1'b1, 1'b1);
        steps2(59);
        adj = 1'b0;
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_st("run_5959", 59, 59, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_st("wrap_0000", 0, 0, 1'b1, 1'b0);

        // Adjust seconds 00:58 -> 00:01, blink, ignored inputs.
        adj = 1'b1;
        sel = 1'b1;
        idle();
        expect_st("adj_from_run", 0, 0, 1'b1, 1'b1);
        steps2(58);
        expect_st("adj_0058", 0, 58, 1'b1, 1'b1);
        steps2(3);
        expect_st("sec_wrap", 0, 1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_st("blink_off", 0, 1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_st("blink_on", 0, 1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_st("adj_1hz_ign", 0, 1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_st("adj_btn_ign", 0, 1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_st("blink_off2", 0, 1, 1'b0, 1'b1);
        adj = 1'b0;
        idle();
        expect_st("exit_en", 0, 1, 1'b1, 1'b1);

        // Clear beats tick while running at 12:34.
        adj = 1'b1;
        sel = 1'b0;
        idle();
        steps2(12);
        sel = 1'b1;
        steps2(33);
        adj = 1'b0;
        idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_st("run_1234", 12, 34, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_st("clr_tick", 0, 0, 1'b1, 1'b0);

        // Pause and tick together at 00:05.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_st("run_0005", 0, 5, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_st("pause_tick", 0, 6, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            expect_st("pause_hold", 0, 6, 1'b1, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_st("clr_paused", 0, 0, 1'b1, 1'b1);

        // Async reset at 07:42 in ADJUST with display blanked.
        adj = 1'b1;
        sel = 1'b0;
        idle();
        steps2(7);
        sel = 1'b1;
        steps2(42);
        expect_st("adj_0742", 7, 42, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_st("blank_0742", 7, 42, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        r.name   = "async_rst";
        r.mt     = 4'd0;
        r.mo     = 4'd0;
        r.st     = 4'd0;
        r.so     = 4'd0;
        r.en     = 1'b1;
        r.paused = 1'b1;
        cmp(r);
        adj = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_st("post_rst", 0, 0, 1'b1, 1'b1);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
